huff_bit_packer: RTL and testbench
==================================

Name: huff_bit_packer

Overview:
- Downstream consumer of the static length/distance Huffman encoders.
- Accepts variable-length codewords, each up to IN_W bits and right-aligned with a valid-bit count, and packs them MSB-first into a continuous bit stream.
- Emits fixed OUT_W-bit words over a ready/valid handshake to the output buffer.
- A flush request drains the residual bits as a zero-padded final word marked with a last flag.

Parameters:
- IN_W, 13: width of data_in; the largest codeword is {8-bit Huffman, 5 extra bits}.
- OUT_W, 16: output word width.
- CNT_W, 24: width of the bit_count statistics counter.
- ACC_W = 2*OUT_W (derived, not overridable): accumulator width; legal only if IN_W <= OUT_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  codeword present.
- in_ready  out  1  packer can accept a codeword/flush this cycle.
- data_in  in  IN_W  codeword, right-aligned; bits at and above bits_in are ignored (masked internally).
- bits_in  in  5  number of valid bits in data_in, 0..IN_W.
- flush_in  in  1  drain request; qualified by in_ready.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  OUT_W  packed word; oldest bit at MSB.
- out_nbits  out  5  valid bits in out_data: OUT_W for full words, 1..OUT_W-1 for the padded last word.
- out_last  out  1  word is the final word of a flush.
- flush_done  out  1  one-cycle pulse when a flush has completed.
- bit_count  out  CNT_W  total bits accepted since reset or the last flush_done; wraps modulo 2^CNT_W.

Behaviour:
- Reset, asynchronous on rst=1: acc=0, fill=0, state=RUN, out_valid=0, out_last=0, out_nbits=0, out_data=0, flush_done=0, bit_count=0.
  - Reset mid-flush abandons all pending bits; no word or flush_done is produced for that flush.
- State: acc[ACC_W-1:0] holds valid bits MSB-aligned in acc[ACC_W-1 -: fill]; fill ranges 0..ACC_W.

State RUN:
- in_ready = (fill <= ACC_W-IN_W) && state==RUN; this gives fill <= 19 for the defaults.
- Input accept: in_valid && in_ready. The masked codeword is placed directly below the existing valid bits.
- out_valid = (fill >= OUT_W). out_data = acc[ACC_W-1 -: OUT_W], out_nbits = OUT_W, out_last = 0.
- Output accept: out_valid && out_ready. acc shifts left by OUT_W, zero-filled, and fill -= OUT_W.
- Simultaneous input and output accept in one cycle: pop first, then append at the post-pop fill.
  - fill_next = fill - OUT_W + bits_in. No bit is lost or reordered.
- bits_in=0 with in_valid is a legal no-op for data.
- Latency: an accepted codeword is visible in out_data on the next cycle if that completes a word.
- Flush accept: flush_in && in_ready. Any in_valid data presented in the same cycle is appended first. The block then enters FLUSH.

State FLUSH:
- in_ready = 0.
- While fill > OUT_W: full words are emitted as in RUN.
- When 0 < fill <= OUT_W:
  - out_valid=1, out_last=1, out_nbits=fill.
  - out_data holds the valid bits MSB-first; the low bits are zero.
  - On accept, fill=0 and the block moves to DONE.
- If fill==0 on entering FLUSH: no word is emitted and the block moves to DONE immediately.

State DONE:
- flush_done=1 for exactly one cycle, and bit_count clears to 0 in that cycle.
- The block returns to RUN on the next cycle, with acc=0.

bit_count:
- Adds bits_in on every input accept.
- If an accept coincides with the clearing in DONE, the clear wins. This cannot actually occur, because in_ready=0 during DONE.

Other rules:
- out_data and out_nbits must stay stable while out_valid=1 and out_ready=0 (AXI-style rule). out_valid must not drop without an accept.
- The out_valid, out_data, out_nbits, out_last and in_ready outputs are decoded from registered state only, with no combinational path from in_valid. in_ready may depend on state and fill only.

Test Plan:
1. data_in=0x001 with bits_in=7, then flush_in -> one word out_data=0x0200, out_nbits=7, out_last=1; flush_done pulses 1 cycle after acceptance; bit_count reads 7 before the clear and 0 after.
2. 0xABC/12 bits, then 0xDEF/12 bits, then flush -> word 0xABCD (nbits 16, last 0), then 0xEF00 (nbits 8, last 1).
3. out_ready=0 with 13-bit codes streamed -> two accepted (fill 26), then in_ready=0 and out_valid=1 with out_data stable across cycles. Raising out_ready drains one word (fill 10) and in_ready reasserts.
4. fill=16 with out_ready=1 and a 13-bit input in the same cycle -> both accepted, fill=13 next cycle; the following word's MSBs equal the new codeword's MSBs.
5. Flush at fill=0 -> out_valid never asserts; flush_done pulses once; in_ready returns the cycle after DONE.
6. rst asserted asynchronously mid-FLUSH with a partial word pending -> all outputs go to their reset values immediately; after release, the next codeword starts a fresh stream with bit_count=0.

Source files
------------

// File: rtl/huff_bit_packer.sv
// Packs right-aligned variable-length codewords MSB-first into OUT_W-bit words.
// A flush drains the residual bits as a zero-padded word flagged out_last.
module huff_bit_packer #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 16,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  data_in,
  input  logic [4:0]       bits_in,
  input  logic             flush_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [4:0]       out_nbits,
  output logic             out_last,
  output logic             flush_done,
  output logic [CNT_W-1:0] bit_count
);
  localparam int ACC_W = 2 * OUT_W;
  localparam int FW    = $clog2(ACC_W + 1);
  localparam logic [FW-1:0] OUT_F   = FW'(OUT_W);
  localparam logic [FW-1:0] ACC_F   = FW'(ACC_W);
  localparam logic [FW-1:0] RDY_MAX = FW'(ACC_W - IN_W);
  localparam logic [4:0]    IN_B    = 5'(IN_W);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [4:0]         bits_eff;
  logic [ACC_W-1:0]   mask, data_al, acc_pop;
  logic [FW-1:0]      fill_pop;
  logic               push, pop, last_pop;

  // Handshake and word outputs depend only on registered state and fill.
  always_comb begin
    in_ready = (state_q == RUN) && (fill_q <= RDY_MAX);
    case (state_q)
      RUN:     out_valid = (fill_q >= OUT_F);
      FLUSH:   out_valid = (fill_q != '0);
      default: out_valid = 1'b0;
    endcase
    out_last   = (state_q == FLUSH) && out_valid && (fill_q <= OUT_F);
    out_data   = out_valid ? acc_q[ACC_W-1 -: OUT_W] : '0;
    out_nbits  = !out_valid ? 5'd0 : (out_last ? 5'(fill_q) : 5'(OUT_W));
    flush_done = (state_q == DONE);
    bit_count  = cnt_q;
  end

  always_comb begin
    bits_eff = (bits_in > IN_B) ? IN_B : bits_in;
    mask     = (ACC_W'(1) << bits_eff) - ACC_W'(1);
    data_al  = (ACC_W'(data_in) & mask) << (ACC_F - FW'(bits_eff));
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    last_pop = pop && out_last;

    // Pop happens before append so a same-cycle codeword lands after the shift.
    acc_pop  = pop ? (acc_q << OUT_W) : acc_q;
    fill_pop = pop ? (fill_q - OUT_F) : fill_q;
    acc_d    = acc_pop | (push ? (data_al >> fill_pop) : '0);
    fill_d   = fill_pop + (push ? FW'(bits_eff) : '0);
    cnt_d    = cnt_q + (push ? CNT_W'(bits_eff) : '0);
    state_d  = state_q;

    case (state_q)
      RUN: begin
        if (flush_in && in_ready) begin
          state_d = (fill_d == '0) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        if (last_pop) begin
          state_d = DONE;
          acc_d   = '0;
          fill_d  = '0;
        end
      end
      default: begin
        state_d = RUN;
        acc_d   = '0;
        fill_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_huff_bit_packer.sv
// Bench for huff_bit_packer: directed flush vectors, handshake corner cases,
// and a randomized run against a bit-queue model of the packed stream.
module tb_huff_bit_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [12:0] dataIn = '0;
  logic [4:0]  bitsIn = '0;
  logic        flushIn = 1'b0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [15:0] outData;
  logic [4:0]  outNbits;
  logic        outLast;
  logic        flushDone;
  logic [23:0] bitCount;

  huff_bit_packer #(.IN_W(13), .OUT_W(16), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .data_in(dataIn), .bits_in(bitsIn), .flush_in(flushIn),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .out_nbits(outNbits), .out_last(outLast), .flush_done(flushDone),
    .bit_count(bitCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] data;
    logic [4:0]  bits;
    logic [15:0] expData;
    logic [4:0]  expNbits;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  bit          q[$];
  int          mState;
  logic [23:0] mCount;
  int          sz;
  bit          expInReady, expOutValid, expLast;
  logic [15:0] expData;
  logic [4:0]  expNbits;
  bit          rV, rFlush, rReady;
  int          rBits;
  logic [12:0] rData;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out waiting, expected event never seen", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [12:0] data, input logic [4:0] bits, input logic valid, input logic flush);
    bit done = 1'b0;
    inValid = valid;
    dataIn  = data;
    bitsIn  = bits;
    flushIn = flush;
    for (int i = 0; i < 40 && !done; i++) begin
      if (inReady) done = 1'b1;
      step();
    end
    inValid = 1'b0;
    flushIn = 1'b0;
    if (!done) failTimeout("acceptWait");
  endtask

  task automatic expectWord(input string name, input logic [15:0] eData, input logic [4:0] eNbits, input logic eLast);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (outValid) seen = 1'b1;
      else step();
    end
    if (!seen) failTimeout($sformatf("%sValid", name));
    else begin
      checkOutput($sformatf("%sData", name), outData, eData);
      checkOutput($sformatf("%sNbits", name), outNbits, eNbits);
      checkOutput($sformatf("%sLast", name), outLast, eLast);
      step();
    end
  endtask

  task automatic waitFlushDone(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (flushDone) seen = 1'b1;
      else step();
    end
    if (!seen) failTimeout($sformatf("%sDone", name));
    else begin
      step();
      checkOutput($sformatf("%sDonePulse", name), flushDone, 1'b0);
      checkOutput($sformatf("%sCountClr", name), bitCount, 24'd0);
      checkOutput($sformatf("%sReady", name), inReady, 1'b1);
    end
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{13'h0001, 5'd7,  16'h0200, 5'd7};
    vecs[1] = '{13'h1FFF, 5'd13, 16'hFFF8, 5'd13};
    vecs[2] = '{13'h1FFF, 5'd3,  16'hE000, 5'd3};
    vecs[3] = '{13'h1235, 5'd8,  16'h3500, 5'd8};
    vecs[4] = '{13'h0AAA, 5'd13, 16'h5550, 5'd13};
    vecs[5] = '{13'h1ABC, 5'd0,  16'h0000, 5'd0};
    vecs[6] = '{13'h0005, 5'd1,  16'h8000, 5'd1};

    #1;
    checkOutput("rstValid", outValid, 1'b0);
    checkOutput("rstLast", outLast, 1'b0);
    checkOutput("rstNbits", outNbits, 5'd0);
    checkOutput("rstData", outData, 16'h0);
    checkOutput("rstDone", flushDone, 1'b0);
    checkOutput("rstCount", bitCount, 24'd0);
    #12 rst = 1'b0;
    step();

    // Single codeword then a separate flush.
    applyStimulus(13'h0001, 5'd7, 1'b1, 1'b0);
    checkOutput("p1Count", bitCount, 24'd7);
    applyStimulus(13'h0000, 5'd0, 1'b0, 1'b1);
    expectWord("p1Word", 16'h0200, 5'd7, 1'b1);
    checkOutput("p1DoneNext", flushDone, 1'b1);
    waitFlushDone("p1");

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].data, vecs[i].bits, 1'b1, 1'b1);
      if (vecs[i].expNbits != 5'd0) expectWord($sformatf("tab%0d", i), vecs[i].expData, vecs[i].expNbits, 1'b1);
      else checkOutput($sformatf("tab%0dNoWord", i), outValid, 1'b0);
      waitFlushDone($sformatf("tab%0d", i));
    end

    applyStimulus(13'h0ABC, 5'd12, 1'b1, 1'b0);
    applyStimulus(13'h0DEF, 5'd12, 1'b1, 1'b0);
    expectWord("p2W0", 16'hABCD, 5'd16, 1'b0);
    applyStimulus(13'h0000, 5'd0, 1'b0, 1'b1);
    expectWord("p2W1", 16'hEF00, 5'd8, 1'b1);
    waitFlushDone("p2");

    // Backpressure: two 13-bit codes fill 26 bits, then input stalls.
    outReady = 1'b0;
    applyStimulus(13'h1555, 5'd13, 1'b1, 1'b0);
    applyStimulus(13'h0F0F, 5'd13, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("p3Ready", inReady, 1'b0);
      checkOutput("p3Valid", outValid, 1'b1);
      checkOutput("p3Hold", outData, 16'hAAAB);
      step();
    end
    checkOutput("p3Count", bitCount, 24'd26);
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    checkOutput("p3ReadyBack", inReady, 1'b1);
    checkOutput("p3ValidLow", outValid, 1'b0);
    outReady = 1'b1;
    applyStimulus(13'h0000, 5'd0, 1'b0, 1'b1);
    expectWord("p3Last", 16'hC3C0, 5'd10, 1'b1);
    waitFlushDone("p3");

    // Pop and append in the same cycle at fill 16.
    outReady = 1'b0;
    applyStimulus(13'h00A5, 5'd8, 1'b1, 1'b0);
    applyStimulus(13'h003C, 5'd8, 1'b1, 1'b0);
    checkOutput("p4Word", outData, 16'hA53C);
    checkOutput("p4Ready", inReady, 1'b1);
    outReady = 1'b1;
    inValid  = 1'b1;
    dataIn   = 13'h1234;
    bitsIn   = 5'd13;
    step();
    inValid = 1'b0;
    checkOutput("p4ValidLow", outValid, 1'b0);
    checkOutput("p4Count", bitCount, 24'd29);
    applyStimulus(13'h0000, 5'd0, 1'b0, 1'b1);
    expectWord("p4Tail", 16'h91A0, 5'd13, 1'b1);
    waitFlushDone("p4");

    applyStimulus(13'h0000, 5'd0, 1'b0, 1'b1);
    checkOutput("p5NoWord", outValid, 1'b0);
    waitFlushDone("p5");

    // Asynchronous reset while a partial word is pending in FLUSH.
    outReady = 1'b0;
    applyStimulus(13'h001F, 5'd5, 1'b1, 1'b1);
    checkOutput("p6Pending", outValid, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("p6Valid", outValid, 1'b0);
    checkOutput("p6Last", outLast, 1'b0);
    checkOutput("p6Nbits", outNbits, 5'd0);
    checkOutput("p6Data", outData, 16'h0);
    checkOutput("p6Count", bitCount, 24'd0);
    @(negedge clk);
    rst = 1'b0;
    outReady = 1'b1;
    step();
    checkOutput("p6Quiet", outValid, 1'b0);
    applyStimulus(13'h0003, 5'd2, 1'b1, 1'b0);
    checkOutput("p6Fresh", bitCount, 24'd2);
    applyStimulus(13'h0000, 5'd0, 1'b0, 1'b1);
    expectWord("p6Word", 16'hC000, 5'd2, 1'b1);
    waitFlushDone("p6");

    // Randomized run against a queue of stream bits.
    q.delete();
    mState = 0;
    mCount = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      sz = q.size();
      expInReady  = (mState == 0) && (sz <= 19);
      expOutValid = (mState == 0) ? (sz >= 16) : ((mState == 1) && (sz > 0));
      expLast     = (mState == 1) && (sz > 0) && (sz <= 16);
      expNbits    = expLast ? 5'(sz) : 5'd16;
      expData     = '0;
      for (int b = 0; b < 16; b++) if (b < sz) expData[15-b] = q[b];
      checkOutput("rndInReady", inReady, expInReady);
      checkOutput("rndOutValid", outValid, expOutValid);
      if (expOutValid) begin
        checkOutput("rndData", outData, expData);
        checkOutput("rndNbits", outNbits, expNbits);
        checkOutput("rndLast", outLast, expLast);
      end
      checkOutput("rndFlushDone", flushDone, mState == 2);
      checkOutput("rndBitCount", bitCount, mCount);

      rV      = ($urandom % 4) != 0;
      rBits   = $urandom_range(0, 13);
      rData   = 13'($urandom);
      rFlush  = ($urandom % 40) == 0;
      rReady  = ($urandom % 3) != 0;
      inValid = rV;
      dataIn  = rData;
      bitsIn  = 5'(rBits);
      flushIn = rFlush;
      outReady = rReady;
      @(posedge clk);
      if (mState == 2) begin
        mState = 0;
        mCount = '0;
      end else begin
        if (expOutValid && rReady) begin
          if (expLast) begin
            q.delete();
            mState = 2;
          end else begin
            repeat (16) void'(q.pop_front());
          end
        end
        if (rV && expInReady) begin
          for (int b = rBits - 1; b >= 0; b--) q.push_back(rData[b]);
          mCount = mCount + 24'(rBits);
        end
        if (rFlush && expInReady) mState = (q.size() == 0) ? 2 : 1;
      end
      #1;
    end
    inValid = 1'b0;
    flushIn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
